// File: rtl/mc_main_control.sv
// Multi-cycle RV32I main control: Moore sequencer plus ALU decoder.
// Optional MC_BNE_EN adds bne handling in the branch state.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  state_t state_q, state_d;
  logic   bad_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    bad_op  = 1'b0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:     state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  logic       pc_upd, branch, br_take;
  logic       adr, mem_we, ir_we, rf_we;
  logic [1:0] alu_op;

  always_comb begin
    pc_upd    = 1'b0;
    branch    = 1'b0;
    adr       = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    alu_op    = 2'b00;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_upd    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: adr = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rf_we     = 1'b1;
      end
      S_MEMWRITE: begin
        adr    = 1'b1;
        mem_we = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: rf_we = 1'b1;
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_upd  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_BNE_EN
  // funct3[0] distinguishes bne from beq
  assign br_take = branch & (funct3[0] ? ~zero : zero);
`else
  assign br_take = branch & zero;
`endif

  assign PCWrite  = rst_n & (pc_upd | br_take);
  assign IRWrite  = rst_n & ir_we;
  assign MemWrite = rst_n & mem_we;
  assign RegWrite = rst_n & rf_we;
  assign illegal  = rst_n & (state_q == S_DECODE) & bad_op;
  assign AdrSrc   = adr;
  assign state_o  = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Random instruction stream against a per-instruction path model.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .state_o(state_o), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;

  function automatic logic legal(input logic [6:0] o);
    return o inside {LW, SW, RT, IT, JAL, BR};
  endfunction

  function automatic logic [2:0] fdec(input logic [6:0] o,
                                      input logic [2:0] f3,
                                      input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Packed: PCW,Adr,MW,IRW,Res[2],A[2],B[2],RW,Imm[2],ALU[3],ill
  function automatic logic [16:0] model(input int st,
                                        input logic [6:0] o,
                                        input logic [2:0] f3,
                                        input logic f7,
                                        input logic z,
                                        input logic rn);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {res, sa, sb} = '0;
    alu = 3'd0;
    if (o == SW)       imm = 2'd1;
    else if (o == BR)  imm = 2'd2;
    else if (o == JAL) imm = 2'd3;
    else               imm = 2'd0;
    case (st)
      0:  begin pcw = 1; irw = 1; sb = 2; res = 2; end
      1:  begin sa = 1; sb = 1; ill = !legal(o); end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = fdec(o, f3, f7); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = fdec(o, f3, f7); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin
        sa = 2; alu = 3'd1;
`ifdef MC_BNE_EN
        pcw = f3[0] ? !z : z;
`else
        pcw = z;
`endif
      end
      default: ;
    endcase
    if (!rn) {pcw, mw, irw, rw, ill} = '0;
    return {pcw, adr, mw, irw, res, sa, sb, rw, imm, alu, ill};
  endfunction

  function automatic logic [16:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
            ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic path(input logic [6:0] o, output int q[$]);
    case (o)
      LW:      q = '{0, 1, 2, 3, 4};
      SW:      q = '{0, 1, 2, 5};
      RT:      q = '{0, 1, 6, 7};
      IT:      q = '{0, 1, 8, 7};
      JAL:     q = '{0, 1, 9, 7};
      BR:      q = '{0, 1, 10};
      default: q = '{0, 1};
    endcase
  endtask

  // One instruction: check each cycle at negedge, advance after posedge
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode);
    int q[$];
    path(o, q);
    op = o; funct3 = f3; funct7b5 = f7;
    foreach (q[i]) begin
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      chk("state", 32'(state_o), 32'(q[i]));
      chk("outs", 32'(obs()),
          32'(model(q[i], o, f3, f7, zero, rst_n)));
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] ops [6] = '{LW, SW, RT, IT, JAL, BR};

  initial begin
    logic [6:0] o;
    rst_n = 0; op = 0; funct3 = 0; funct7b5 = 0; zero = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outs", 32'(obs()), 32'(model(0, op, 0, 0, 0, 0)));
    @(posedge clk); #1;
    rst_n = 1;

    run_instr(LW, 3'd2, 1'b0, -1);
    run_instr(SW, 3'd2, 1'b0, -1);
    run_instr(RT, 3'b000, 1'b1, -1);
    run_instr(RT, 3'b111, 1'b0, -1);
    run_instr(BR, 3'b000, 1'b0, 1);
    run_instr(BR, 3'b000, 1'b0, 0);
    run_instr(BR, 3'b001, 1'b0, 0);
    run_instr(BR, 3'b001, 1'b0, 1);
    run_instr(7'b0000000, 3'd0, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 7'($urandom); while (legal(o));
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      run_instr(o, 3'($urandom), 1'($urandom), -1);
    end

    // Reset asserted while in MEMWRITE
    op = SW; funct3 = 3'd2; funct7b5 = 0; zero = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_state", 32'(state_o), 32'd5);
    chk("mid_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("mid_rst_outs", 32'(obs()), 32'(model(5, SW, 2, 0, 0, 0)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_state", 32'(state_o), 32'd0);
    chk("post_rst_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("release_state", 32'(state_o), 32'd0);
    chk("release_irwrite", 32'(IRWrite), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_decode", 32'(state_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
